// File: rtl/multi_color_tracking_if.sv
// Pixel-stream and result bus for multi_color_tracking.
// Macro TRACKING_PIXCOUNT_EN adds the per-channel pix_count result field.
// Signals:
//   in_valid/in_ready/in_sof/in_rgb : pixel stream handshake and payload
//   thr_lo/thr_hi                   : per-channel inclusive RGB windows
//   out_valid/out_found/center_x/center_y/width/height : frame report
//   frame_err                       : framing-error strobe
// master = pixel source / result consumer, slave = tracker.
interface multi_color_tracking_if #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned COORD_W = 12
);
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_sof;
    logic [23:0]                 in_rgb;
    logic [NUM_CH*24-1:0]        thr_lo;
    logic [NUM_CH*24-1:0]        thr_hi;
    logic                        out_valid;
    logic [NUM_CH-1:0]           out_found;
    logic [NUM_CH*COORD_W-1:0]   center_x;
    logic [NUM_CH*COORD_W-1:0]   center_y;
    logic [NUM_CH*COORD_W-1:0]   width;
    logic [NUM_CH*COORD_W-1:0]   height;
    logic                        frame_err;
`ifdef TRACKING_PIXCOUNT_EN
    logic [NUM_CH*20-1:0]        pix_count;
`endif

    modport master (
        output in_valid, in_sof, in_rgb, thr_lo, thr_hi,
`ifdef TRACKING_PIXCOUNT_EN
        input  pix_count,
`endif
        input  in_ready, out_valid, out_found, center_x, center_y, width, height, frame_err
    );

    modport slave (
        input  in_valid, in_sof, in_rgb, thr_lo, thr_hi,
`ifdef TRACKING_PIXCOUNT_EN
        output pix_count,
`endif
        output in_ready, out_valid, out_found, center_x, center_y, width, height, frame_err
    );
endinterface

// File: rtl/multi_color_tracking.sv
// Per-channel colour-window bounding-box tracker over a raster pixel stream.
// Ports: clock_50 (clock), reset (async, active-high), bus (slave modport of
// multi_color_tracking_if: pixel stream in, thresholds in, frame report out).
// Optional macro TRACKING_PIXCOUNT_EN: per-channel match counters, reported on
// bus.pix_count; a channel is only "found" with at least MIN_PIX matches.
module multi_color_tracking #(
    parameter int unsigned WIDTH   = 640,
    parameter int unsigned HEIGHT  = 480,
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned COORD_W = 12
`ifdef TRACKING_PIXCOUNT_EN
    , parameter int unsigned MIN_PIX = 16
`endif
) (
    input  logic                   clock_50,
    input  logic                   reset,
    multi_color_tracking_if.slave  bus
);

    localparam int unsigned CNT_W = 20;
    localparam logic [1:0] S_SYNC   = 2'd0;
    localparam logic [1:0] S_SCAN   = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

    logic [1:0]                state_q, state_d;
    logic [COORD_W-1:0]        x_q, x_d, y_q, y_d;
    logic [NUM_CH-1:0]         hit_q, hit_d;
    logic [COORD_W-1:0]        min_x_q [NUM_CH], min_x_d [NUM_CH];
    logic [COORD_W-1:0]        max_x_q [NUM_CH], max_x_d [NUM_CH];
    logic [COORD_W-1:0]        min_y_q [NUM_CH], min_y_d [NUM_CH];
    logic [COORD_W-1:0]        max_y_q [NUM_CH], max_y_d [NUM_CH];
    logic                      out_valid_q, out_valid_d;
    logic                      frame_err_q, frame_err_d;
    logic [NUM_CH-1:0]         found_q, found_d;
    logic [NUM_CH*COORD_W-1:0] cx_q, cx_d, cy_q, cy_d, wd_q, wd_d, ht_q, ht_d;
`ifdef TRACKING_PIXCOUNT_EN
    logic [CNT_W-1:0]          cnt_q [NUM_CH], cnt_d [NUM_CH];
    logic [NUM_CH*CNT_W-1:0]   pc_q, pc_d;
`endif

    logic                      xfer;
    logic                      at_origin;
    logic                      clr, take;
    logic [COORD_W-1:0]        px, py;
    logic [COORD_W:0]          sum_x, sum_y;
    logic [NUM_CH-1:0]         match;

    // Ready in every state but REPORT, and never while reset is held.
    assign bus.in_ready = (state_q != S_REPORT) && !reset;
    assign xfer         = bus.in_valid && bus.in_ready;
    assign at_origin    = (x_q == '0) && (y_q == '0);

    // Inclusive per-component window test; lo > hi can never match.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            match[k] = 1'b1;
            for (int c = 0; c < 3; c++) begin
                if (bus.in_rgb[8*c +: 8] < bus.thr_lo[24*k + 8*c +: 8] ||
                    bus.in_rgb[8*c +: 8] > bus.thr_hi[24*k + 8*c +: 8])
                    match[k] = 1'b0;
            end
        end
    end

    // Next-state, raster position, bounding boxes and report registers.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        hit_d       = hit_q;
        min_x_d     = min_x_q;
        max_x_d     = max_x_q;
        min_y_d     = min_y_q;
        max_y_d     = max_y_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
        found_d     = found_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        wd_d        = wd_q;
        ht_d        = ht_q;
`ifdef TRACKING_PIXCOUNT_EN
        cnt_d       = cnt_q;
        pc_d        = pc_q;
`endif
        clr         = 1'b0;
        take        = 1'b0;
        px          = x_q;
        py          = y_q;
        sum_x       = '0;
        sum_y       = '0;

        case (state_q)
            S_SYNC: begin
                if (xfer && bus.in_sof) begin
                    clr     = 1'b1;
                    take    = 1'b1;
                    px      = '0;
                    py      = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (xfer) begin
                    if (bus.in_sof) begin
                        // Early start-of-frame restarts the frame at the origin.
                        frame_err_d = !at_origin;
                        clr         = 1'b1;
                        take        = 1'b1;
                        px          = '0;
                        py          = '0;
                    end else if (at_origin) begin
                        // Lost frame alignment: drop and resynchronise.
                        frame_err_d = 1'b1;
                        state_d     = S_SYNC;
                    end else begin
                        take = 1'b1;
                    end
                end
            end
            S_REPORT: begin
                out_valid_d = 1'b1;
                for (int k = 0; k < NUM_CH; k++) begin
`ifdef TRACKING_PIXCOUNT_EN
                    found_d[k] = hit_q[k] && (cnt_q[k] >= CNT_W'(MIN_PIX));
                    pc_d[k*CNT_W +: CNT_W] = cnt_q[k];
`else
                    found_d[k] = hit_q[k];
`endif
                    // Channels without a result keep their previous box.
                    if (found_d[k]) begin
                        sum_x = {1'b0, min_x_q[k]} + {1'b0, max_x_q[k]};
                        sum_y = {1'b0, min_y_q[k]} + {1'b0, max_y_q[k]};
                        cx_d[k*COORD_W +: COORD_W] = sum_x[COORD_W:1];
                        cy_d[k*COORD_W +: COORD_W] = sum_y[COORD_W:1];
                        wd_d[k*COORD_W +: COORD_W] = COORD_W'(max_x_q[k] - min_x_q[k] + COORD_W'(1));
                        ht_d[k*COORD_W +: COORD_W] = COORD_W'(max_y_q[k] - min_y_q[k] + COORD_W'(1));
                    end
                end
                clr     = 1'b1;
                x_d     = '0;
                y_d     = '0;
                state_d = S_SCAN;
            end
            default: state_d = S_SYNC;
        endcase

        if (clr) begin
            hit_d = '0;
            for (int k = 0; k < NUM_CH; k++) begin
                min_x_d[k] = '0;
                max_x_d[k] = '0;
                min_y_d[k] = '0;
                max_y_d[k] = '0;
`ifdef TRACKING_PIXCOUNT_EN
                cnt_d[k]   = '0;
`endif
            end
        end

        if (take) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (match[k]) begin
                    if (!hit_d[k]) begin
                        min_x_d[k] = px;
                        max_x_d[k] = px;
                        min_y_d[k] = py;
                        max_y_d[k] = py;
                    end else begin
                        if (px < min_x_d[k]) min_x_d[k] = px;
                        if (px > max_x_d[k]) max_x_d[k] = px;
                        if (py < min_y_d[k]) min_y_d[k] = py;
                        if (py > max_y_d[k]) max_y_d[k] = py;
                    end
                    hit_d[k] = 1'b1;
`ifdef TRACKING_PIXCOUNT_EN
                    cnt_d[k] = cnt_d[k] + CNT_W'(1);
`endif
                end
            end
            // Raster advance; the last pixel of the frame triggers the report.
            if (px == X_LAST) begin
                x_d = '0;
                if (py == Y_LAST) begin
                    y_d     = '0;
                    state_d = S_REPORT;
                end else begin
                    y_d = py + COORD_W'(1);
                end
            end else begin
                x_d = px + COORD_W'(1);
                y_d = py;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            state_q     <= S_SYNC;
            x_q         <= '0;
            y_q         <= '0;
            hit_q       <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            found_q     <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            wd_q        <= '0;
            ht_q        <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                min_x_q[k] <= '0;
                max_x_q[k] <= '0;
                min_y_q[k] <= '0;
                max_y_q[k] <= '0;
`ifdef TRACKING_PIXCOUNT_EN
                cnt_q[k]   <= '0;
`endif
            end
`ifdef TRACKING_PIXCOUNT_EN
            pc_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            hit_q       <= hit_d;
            min_x_q     <= min_x_d;
            max_x_q     <= max_x_d;
            min_y_q     <= min_y_d;
            max_y_q     <= max_y_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            found_q     <= found_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            wd_q        <= wd_d;
            ht_q        <= ht_d;
`ifdef TRACKING_PIXCOUNT_EN
            cnt_q       <= cnt_d;
            pc_q        <= pc_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.out_found = found_q;
    assign bus.center_x  = cx_q;
    assign bus.center_y  = cy_q;
    assign bus.width     = wd_q;
    assign bus.height    = ht_q;
`ifdef TRACKING_PIXCOUNT_EN
    assign bus.pix_count = pc_q;
`endif

endmodule

// File: tb/tb_multi_color_tracking.sv
// Directed bench for multi_color_tracking on an 8x4 raster with two channels.
// Channel 0 window: green (R,B <= 50, G >= 50); channel 1 window: red.
module tb_multi_color_tracking;

    localparam logic [23:0] BLK = 24'h000000;
    localparam logic [23:0] GRN = 24'h00FF00;
    localparam logic [23:0] RED = 24'hFF0000;

    logic clock_50 = 1'b0;
    logic reset    = 1'b1;
    int   tests    = 0;
    int   fails    = 0;
    int   cyc      = 0;
    int   ov_count = 0;
    int   fe_count = 0;
    int   rdy_low  = 0;
    int   last_ov  = 0;
    int   ov_gap   = 0;
    logic [23:0] frame_pix [0:31];

    multi_color_tracking_if #(.NUM_CH(2), .COORD_W(12)) bus ();

    multi_color_tracking #(
        .WIDTH(8), .HEIGHT(4), .NUM_CH(2), .COORD_W(12)
`ifdef TRACKING_PIXCOUNT_EN
        , .MIN_PIX(3)
`endif
    ) dut (
        .clock_50 (clock_50),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clock_50 = ~clock_50;

    always @(posedge clock_50) cyc <= cyc + 1;

    // Event monitor sampled mid-cycle.
    always @(negedge clock_50) begin
        if (!reset) begin
            if (bus.out_valid) begin
                ov_count <= ov_count + 1;
                ov_gap   <= cyc - last_ov;
                last_ov  <= cyc;
            end
            if (bus.frame_err) fe_count <= fe_count + 1;
            if (!bus.in_ready) rdy_low <= rdy_low + 1;
        end
    end

    task automatic clear_counts();
        ov_count = 0;
        fe_count = 0;
        rdy_low  = 0;
    endtask

    task automatic clear_frame(input logic [23:0] v);
        for (int i = 0; i < 32; i++) frame_pix[i] = v;
    endtask

    task automatic set_pix(input int x, input int y, input logic [23:0] v);
        frame_pix[y*8 + x] = v;
    endtask

    task automatic push(input logic sof, input logic [23:0] rgb);
        int n;
        bit done;
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_rgb   = rgb;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clock_50);
            if (bus.in_ready) done = 1'b1;
            else begin
                n++;
                if (n > 50) begin
                    $display("FAIL push_timeout in_ready stuck at %b, required 1", bus.in_ready);
                    fails++; tests++;
                    done = 1'b1;
                end
            end
        end
        @(posedge clock_50);
        #1;
    endtask

    task automatic push_frame_from(input int first);
        for (int i = first; i < 32; i++) push(i == 0, frame_pix[i]);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        repeat (n) @(posedge clock_50);
        #1;
    endtask

    task automatic set_default_thr();
        bus.thr_lo = {24'hC80000, 24'h003200};
        bus.thr_hi = {24'hFF3232, 24'h32FF32};
    endtask

    task automatic test_reset();
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin $display("FAIL rst_ready got %b exp 0", bus.in_ready); fails++; end
        tests++; if (bus.out_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.out_found !== 2'b00) begin
            $display("FAIL rst_flags got v=%b e=%b f=%b exp 0 0 00", bus.out_valid, bus.frame_err, bus.out_found); fails++; end
        tests++; if (bus.center_x !== 24'd0 || bus.center_y !== 24'd0 || bus.width !== 24'd0 || bus.height !== 24'd0) begin
            $display("FAIL rst_box got %h %h %h %h exp 0", bus.center_x, bus.center_y, bus.width, bus.height); fails++; end
        @(negedge clock_50);
        reset = 1'b0;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin $display("FAIL sync_ready got %b exp 1", bus.in_ready); fails++; end
    endtask

    task automatic build_bbox_frame();
        clear_frame(BLK);
        set_pix(2, 1, GRN); set_pix(5, 1, GRN); set_pix(3, 3, GRN);
    endtask

    task automatic test_bbox();
        clear_counts();
        push(1'b0, GRN); push(1'b0, GRN); push(1'b0, GRN);
        build_bbox_frame();
        push_frame_from(0);
        idle(5);
        tests++; if (ov_count !== 1) begin $display("FAIL bbox_ovcount got %0d exp 1", ov_count); fails++; end
        tests++; if (bus.out_found !== 2'b01) begin $display("FAIL bbox_found got %b exp 01", bus.out_found); fails++; end
        tests++; if (bus.center_x[11:0] !== 12'd3 || bus.center_y[11:0] !== 12'd2) begin
            $display("FAIL bbox_center got (%0d,%0d) exp (3,2)", bus.center_x[11:0], bus.center_y[11:0]); fails++; end
        tests++; if (bus.width[11:0] !== 12'd4 || bus.height[11:0] !== 12'd3) begin
            $display("FAIL bbox_size got %0dx%0d exp 4x3", bus.width[11:0], bus.height[11:0]); fails++; end
        tests++; if (bus.center_x[23:12] !== 12'd0 || bus.width[23:12] !== 12'd0) begin
            $display("FAIL bbox_ch1_hold got cx=%0d w=%0d exp 0 0", bus.center_x[23:12], bus.width[23:12]); fails++; end
        tests++; if (fe_count !== 0) begin $display("FAIL bbox_ferr got %0d exp 0", fe_count); fails++; end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        build_bbox_frame();
        push_frame_from(0);
        clear_frame(BLK);
        set_pix(1, 0, GRN); set_pix(6, 3, GRN); set_pix(3, 2, GRN);
        push_frame_from(0);
        idle(10);
        tests++; if (ov_count !== 2) begin $display("FAIL b2b_ovcount got %0d exp 2", ov_count); fails++; end
        tests++; if (ov_gap !== 33) begin $display("FAIL b2b_gap got %0d exp 33", ov_gap); fails++; end
        tests++; if (rdy_low !== 2) begin $display("FAIL b2b_ready_low got %0d exp 2", rdy_low); fails++; end
        tests++; if (fe_count !== 0) begin $display("FAIL b2b_ferr got %0d exp 0", fe_count); fails++; end
        tests++; if (bus.center_x[11:0] !== 12'd3 || bus.center_y[11:0] !== 12'd1 ||
                     bus.width[11:0] !== 12'd6 || bus.height[11:0] !== 12'd4) begin
            $display("FAIL b2b_box got c=(%0d,%0d) s=%0dx%0d exp c=(3,1) s=6x4", bus.center_x[11:0],
                     bus.center_y[11:0], bus.width[11:0], bus.height[11:0]); fails++; end
    endtask

    task automatic test_sof_mid();
        clear_counts();
        // Partial frame up to (3,2) with greens that must be discarded.
        clear_frame(BLK);
        set_pix(1, 0, GRN); set_pix(7, 0, GRN);
        for (int i = 0; i < 20; i++) push(i == 0, frame_pix[i]);
        // New origin arrives where (4,2) was expected.
        clear_frame(BLK);
        set_pix(3, 1, GRN); set_pix(4, 2, GRN); set_pix(2, 2, GRN);
        push_frame_from(0);
        idle(5);
        tests++; if (fe_count !== 1) begin $display("FAIL sofmid_ferr got %0d exp 1", fe_count); fails++; end
        tests++; if (ov_count !== 1) begin $display("FAIL sofmid_ovcount got %0d exp 1", ov_count); fails++; end
        tests++; if (bus.center_x[11:0] !== 12'd3 || bus.center_y[11:0] !== 12'd1 ||
                     bus.width[11:0] !== 12'd3 || bus.height[11:0] !== 12'd2) begin
            $display("FAIL sofmid_box got c=(%0d,%0d) s=%0dx%0d exp c=(3,1) s=3x2", bus.center_x[11:0],
                     bus.center_y[11:0], bus.width[11:0], bus.height[11:0]); fails++; end
    endtask

    task automatic test_two_channel();
        clear_counts();
        clear_frame(BLK);
        set_pix(6, 2, GRN); set_pix(6, 3, GRN); set_pix(5, 2, GRN);
        set_pix(0, 0, RED); set_pix(7, 3, RED); set_pix(2, 1, RED);
        push_frame_from(0);
        idle(5);
        tests++; if (bus.out_found !== 2'b11) begin $display("FAIL two_found got %b exp 11", bus.out_found); fails++; end
        tests++; if (bus.center_x !== {12'd3, 12'd5} || bus.center_y !== {12'd1, 12'd2}) begin
            $display("FAIL two_center got x=%h y=%h exp x=003005 y=001002", bus.center_x, bus.center_y); fails++; end
        tests++; if (bus.width !== {12'd8, 12'd2} || bus.height !== {12'd4, 12'd2}) begin
            $display("FAIL two_size got w=%h h=%h exp w=008002 h=004002", bus.width, bus.height); fails++; end
    endtask

    task automatic test_origin_no_sof();
        clear_counts();
        push(1'b0, GRN);
        push(1'b0, GRN); push(1'b0, GRN);
        // Inverted window on channel 1 must never match.
        bus.thr_lo[47:24] = 24'h505050;
        bus.thr_hi[47:24] = 24'h404040;
        clear_frame(24'h454545);
        push_frame_from(0);
        idle(5);
        set_default_thr();
        tests++; if (fe_count !== 1) begin $display("FAIL nosof_ferr got %0d exp 1", fe_count); fails++; end
        tests++; if (ov_count !== 1) begin $display("FAIL nosof_ovcount got %0d exp 1", ov_count); fails++; end
        tests++; if (bus.out_found !== 2'b00) begin $display("FAIL hold_found got %b exp 00", bus.out_found); fails++; end
        tests++; if (bus.center_x !== {12'd3, 12'd5} || bus.width !== {12'd8, 12'd2} || bus.height !== {12'd4, 12'd2}) begin
            $display("FAIL hold_box got cx=%h w=%h h=%h exp 003005 008002 004002", bus.center_x, bus.width, bus.height); fails++; end
    endtask

    task automatic test_reset_mid();
        build_bbox_frame();
        for (int i = 0; i < 10; i++) push(i == 0, frame_pix[i]);
        @(negedge clock_50);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        tests++; if (bus.in_ready !== 1'b0 || bus.out_found !== 2'b00 || bus.center_x !== 24'd0 ||
                     bus.center_y !== 24'd0 || bus.width !== 24'd0 || bus.height !== 24'd0) begin
            $display("FAIL midrst_out got rdy=%b f=%b cx=%h cy=%h w=%h h=%h exp all 0", bus.in_ready,
                     bus.out_found, bus.center_x, bus.center_y, bus.width, bus.height); fails++; end
        repeat (3) @(posedge clock_50);
        @(negedge clock_50);
        reset = 1'b0;
        clear_counts();
        for (int i = 10; i < 32; i++) push(1'b0, frame_pix[i]);
        idle(5);
        tests++; if (ov_count !== 0) begin $display("FAIL midrst_partial got %0d exp 0", ov_count); fails++; end
        push_frame_from(0);
        idle(40);
        tests++; if (ov_count !== 1) begin $display("FAIL midrst_ovcount got %0d exp 1", ov_count); fails++; end
        tests++; if (bus.out_found !== 2'b01 || bus.center_x[11:0] !== 12'd3 || bus.width[11:0] !== 12'd4) begin
            $display("FAIL midrst_box got f=%b cx=%0d w=%0d exp 01 3 4", bus.out_found,
                     bus.center_x[11:0], bus.width[11:0]); fails++; end
    endtask

`ifdef TRACKING_PIXCOUNT_EN
    task automatic test_pixcount();
        clear_frame(BLK);
        set_pix(1, 1, RED); set_pix(2, 2, RED);
        push_frame_from(0);
        idle(5);
        tests++; if (bus.out_found[1] !== 1'b0 || bus.pix_count[39:20] !== 20'd2) begin
            $display("FAIL pc_two got f1=%b pc=%0d exp 0 2", bus.out_found[1], bus.pix_count[39:20]); fails++; end
        set_pix(3, 3, RED);
        push_frame_from(0);
        idle(5);
        tests++; if (bus.out_found[1] !== 1'b1 || bus.pix_count[39:20] !== 20'd3) begin
            $display("FAIL pc_three got f1=%b pc=%0d exp 1 3", bus.out_found[1], bus.pix_count[39:20]); fails++; end
        tests++; if (bus.center_x[23:12] !== 12'd2 || bus.width[23:12] !== 12'd3) begin
            $display("FAIL pc_box got cx=%0d w=%0d exp 2 3", bus.center_x[23:12], bus.width[23:12]); fails++; end
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_rgb   = BLK;
        set_default_thr();
        test_reset();
        test_bbox();
        test_back_to_back();
        test_sof_mid();
        test_two_channel();
        test_origin_no_sof();
        test_reset_mid();
`ifdef TRACKING_PIXCOUNT_EN
        test_pixcount();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multi_color_tracking.md
MULTI_COLOR_TRACKING -- requirements
Module: multi_color_tracking

Interface
REQ-001 Parameters SHALL be: WIDTH, 640, pixels per line; HEIGHT, 480, lines per frame; NUM_CH, 2, colour channels tracked; COORD_W, 12, coordinate width; MIN_PIX, 16, minimum matches per channel for found (macro only).
REQ-002 Ports SHALL be:
- clock_50  in  1  single clock for all logic
- reset  in  1  asynchronous, active-high
- in_valid  in  1  pixel present
- in_ready  out  1  block accepts pixel this cycle
- in_sof  in  1  pixel is frame origin (0,0)
- in_rgb  in  24  {R[23:16],G[15:8],B[7:0]}
- thr_lo  in  NUM_CH*24  per-channel lower bound {R,G,B}, channel k at [24k+23:24k]
- thr_hi  in  NUM_CH*24  per-channel upper bound, same packing
- out_valid  out  1  one-cycle result strobe
- out_found  out  NUM_CH  channel k object present in reported frame
- center_x, center_y  out  NUM_CH*COORD_W  bounding-box centre per channel
- width, height  out  NUM_CH*COORD_W  bounding-box size per channel
- frame_err  out  1  one-cycle framing-error strobe

Function
REQ-003 Transfer SHALL occur on a clock_50 edge with in_valid && in_ready; no other cycle SHALL change coordinates or boxes.
REQ-004 FSM SHALL have states SYNC, SCAN, REPORT; in_ready SHALL be 1 in SYNC and SCAN, 0 in REPORT.
REQ-005 SYNC: transfers with in_sof=0 SHALL be dropped; transfer with in_sof=1 SHALL be processed as (0,0), clear all boxes first, go SCAN.
REQ-006 SCAN: x SHALL increment per transfer, wrap WIDTH-1 -> 0 and increment y; transfer at (WIDTH-1,HEIGHT-1) SHALL be processed then go REPORT.
REQ-007 Pixel SHALL match channel k iff thr_lo <= component <= thr_hi for all of R, G, B (unsigned, inclusive).
REQ-008 First match per frame SHALL load min_x=max_x=x, min_y=max_y=y; later matches SHALL update min/max independently (true bounding box, not first/last pixel).
REQ-009 REPORT (exactly one cycle) SHALL register per channel: center=(min+max)>>1 computed in COORD_W+1 bits; width=max_x-min_x+1; height=max_y-min_y+1; then clear boxes, reset coords to (0,0), go SCAN.
REQ-010 out_valid SHALL pulse one cycle, the cycle after REPORT, with outputs updated that same cycle; a transfer may occur in that cycle.
REQ-011 Channel with no match SHALL report out_found=0 and hold its previous center/width/height.
REQ-012 in_sof=1 in SCAN at coordinate other than (0,0) SHALL pulse frame_err, clear boxes, process pixel as (0,0) and stay SCAN.
REQ-013 Transfer in SCAN at (0,0) with in_sof=0 SHALL pulse frame_err, drop pixel, go SYNC.
REQ-014 Threshold changes SHALL take effect on the next transfer; lo>hi SHALL never match.

Reset
REQ-015 reset high SHALL immediately force state SYNC, in_ready=0 while asserted, and out_valid, out_found, frame_err, center_x, center_y, width, height, coordinates, boxes to 0.
REQ-016 Reset mid-frame SHALL discard the partial frame; no out_valid SHALL follow until a complete frame after an in_sof.

Configuration
REQ-017 With TRACKING_PIXCOUNT_EN defined: port pix_count out NUM_CH*20 SHALL exist, count matches per channel, be reported with out_valid; out_found[k] SHALL require count >= MIN_PIX.
REQ-018 Without TRACKING_PIXCOUNT_EN: no pix_count port or counters; out_found[k]=1 on any match.

Verification (WIDTH=8, HEIGHT=4, NUM_CH=2, COORD_W=12)
REQ-019 Ch0 window R,B<=50, G>=50; green pixels at (2,1),(5,1),(3,3), rest black -> out_valid once, found=01, center=(3,2), width=4, height=3.
REQ-020 Two full frames back-to-back, in_valid always 1 -> in_ready low exactly one cycle per frame, out_valid 2 pulses 33 cycles apart, no frame_err.
REQ-021 in_sof asserted at pixel (4,2) -> frame_err one cycle, boxes restart, report 32 transfers later covers only new frame.
REQ-022 reset pulsed after 10 pixels, then full frame with in_sof -> outputs 0 during reset, exactly one out_valid afterwards.
REQ-023 Macro on, MIN_PIX=3, ch1 matches 2 pixels -> out_found[1]=0, pix_count ch1=2; with 3 pixels -> out_found[1]=1, pix_count=3.
